// File: rtl/rsa_xcel_mont_param_xcel_pkg.sv
// Shared definitions for the parametrised RSA Montgomery accelerator:
// xcel message formats, register map, control/phase encodings.
package rsa_xcel_mont_param_pkg;

  // xcel register addresses
  localparam logic [4:0] XR_GO   = 5'd0;
  localparam logic [4:0] XR_BASE = 5'd1;
  localparam logic [4:0] XR_EXP  = 5'd2;
  localparam logic [4:0] XR_MOD  = 5'd3;
  localparam logic [4:0] XR_R2   = 5'd4;
  localparam logic [4:0] XR_RES  = 5'd5;
  localparam logic [4:0] XR_CYC  = 5'd6;

  // message type field values
  localparam logic MSG_READ  = 1'b0;
  localparam logic MSG_WRITE = 1'b1;

  // top-level control states
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] CALC = 1'b1;

  // which Montgomery product of the exponentiation is in flight
  typedef enum logic [2:0] {
    PRE_B   = 3'd0,
    PRE_ACC = 3'd1,
    SQR     = 3'd2,
    MUL     = 3'd3,
    POST    = 3'd4
  } phase_e;

  typedef struct packed {
    logic        msg_type;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [7:0]  opaque;
  } xcel_req_t;

  typedef struct packed {
    logic        msg_type;
    logic [31:0] data;
    logic [7:0]  opaque;
  } xcel_resp_t;

endpackage

// File: rtl/rsa_xcel_mont_param_xcel_if.sv
// xcel request/response stream bundle between host and accelerator.
interface rsa_xcel_mont_param_xcel_if;
  import rsa_xcel_mont_param_pkg::*;

  xcel_req_t  xcel_reqstream_msg;
  logic       xcel_reqstream_val;
  logic       xcel_reqstream_rdy;
  xcel_resp_t xcel_respstream_msg;
  logic       xcel_respstream_val;
  logic       xcel_respstream_rdy;

  modport master (
    output xcel_reqstream_msg, xcel_reqstream_val, xcel_respstream_rdy,
    input  xcel_reqstream_rdy, xcel_respstream_msg, xcel_respstream_val
  );

  modport slave (
    input  xcel_reqstream_msg, xcel_reqstream_val, xcel_respstream_rdy,
    output xcel_reqstream_rdy, xcel_respstream_msg, xcel_respstream_val
  );
endinterface

// File: rtl/rsa_xcel_mont_param_xcel_montmul.sv
// Bit-serial radix-2 Montgomery multiplier: result = a*b*2^-NBITS mod n.
// start is sampled on the edge that also performs bit 0, so a product takes
// NBITS+1 edges and a new start may coincide with the done cycle.
module rsa_xcel_mont_MontMulSerial #(
  parameter int NBITS = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [NBITS-1:0] a,
  input  logic [NBITS-1:0] b,
  input  logic [NBITS-1:0] n,
  output logic             done,
  output logic [NBITS-1:0] result
);
  localparam int CW = $clog2(NBITS + 1);
  localparam logic [CW-1:0] LAST = CW'(NBITS);

  logic             busy;
  logic [CW-1:0]    cnt;
  logic [NBITS-1:0] a_sh;
  logic [NBITS-1:0] b_q;
  logic [NBITS-1:0] n_q;
  logic [NBITS+1:0] t;

  // one reduction step: add a_i*b, make even by adding n, halve
  function automatic logic [NBITS+1:0] step(input logic [NBITS+1:0] t_in,
                                            input logic bit_in,
                                            input logic [NBITS-1:0] bv,
                                            input logic [NBITS-1:0] nv);
    logic [NBITS+1:0] s;
    s = t_in + (bit_in ? {2'b00, bv} : '0);
    if (s[0]) s = s + {2'b00, nv};
    return s >> 1;
  endfunction

  // iterate over the bits of a, then one conditional-subtract cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= 1'b0;
      cnt  <= '0;
      a_sh <= '0;
      b_q  <= '0;
      n_q  <= '0;
      t    <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        b_q  <= b;
        n_q  <= n;
        a_sh <= a >> 1;
        t    <= step('0, a[0], b, n);
        cnt  <= CW'(1);
        busy <= 1'b1;
      end else if (busy) begin
        if (cnt == LAST) begin
          if (t >= {2'b00, n_q}) t <= t - {2'b00, n_q};
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          t    <= step(t, a_sh[0], b_q, n_q);
          a_sh <= a_sh >> 1;
          cnt  <= cnt + 1'b1;
        end
      end
    end
  end

  assign result = t[NBITS-1:0];
endmodule

// File: rtl/rsa_xcel_mont_param_xcel.sv
// RSA modular exponentiation accelerator on the xcel req/resp streams.
// Left-to-right square-and-multiply over a serial Montgomery multiplier.
// Optional: define RSA_XCEL_MONT_CYCLE_COUNT_EN to build the xr6 cycle counter.
module rsa_xcel_mont_param_xcel
  import rsa_xcel_mont_param_pkg::*;
#(
  parameter int NBITS = 64
) (
  input logic clk,
  input logic reset,
  rsa_xcel_mont_param_xcel_if.slave xcel
);
  localparam int NW = NBITS / 32;
  localparam int PW = (NW > 1) ? $clog2(NW) : 1;
  localparam int IW = $clog2(NBITS);
  localparam logic [PW-1:0] PTR_RST  = (NW > 1) ? PW'(1) : PW'(0);
  localparam logic [PW-1:0] PTR_LAST = PW'(NW - 1);
  localparam logic [NBITS-1:0] ONE   = NBITS'(1);

  xcel_req_t        req;
  logic             req_fire, go_fire;
  logic [0:0]       state;
  phase_e           phase, phase_next;
  logic [IW-1:0]    bit_idx, idx_next;
  logic [NBITS-1:0] base, exp, mod, r2, bm, res;
  logic [PW-1:0]    ptr;
  logic             resp_val;
  xcel_resp_t       resp_msg;
  logic [31:0]      rd_data, cyc_word;
  logic             mm_start, mm_done, finish;
  logic [NBITS-1:0] mm_a, mm_b, mm_result;
  logic [31:0]      res_words [2**PW];

  assign req      = xcel.xcel_reqstream_msg;
  assign req_fire = xcel.xcel_reqstream_val && xcel.xcel_reqstream_rdy;
  assign go_fire  = req_fire && (req.msg_type == MSG_WRITE) && (req.addr == XR_GO);

  assign xcel.xcel_reqstream_rdy  = (state != CALC) && (!resp_val || xcel.xcel_respstream_rdy);
  assign xcel.xcel_respstream_val = resp_val;
  assign xcel.xcel_respstream_msg = resp_msg;

  // new word enters at the top; NW writes leave the first word at the bottom
  function automatic logic [NBITS-1:0] shift_in(input logic [NBITS-1:0] cur,
                                                input logic [31:0] w);
    logic [NBITS+31:0] cat;
    cat = {w, cur};
    return cat[NBITS+31:32];
  endfunction

  // result split into readable words, padded to a power of two
  for (genvar gi = 0; gi < 2**PW; gi++) begin : g_words
    if (gi < NW) begin : g_live
      assign res_words[gi] = res[gi*32 +: 32];
    end else begin : g_pad
      assign res_words[gi] = '0;
    end
  end

`ifdef RSA_XCEL_MONT_CYCLE_COUNT_EN
  logic [31:0] cyc_cnt;
  // count CALC cycles of the latest operation, saturating
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                cyc_cnt <= '0;
    else if (go_fire)                         cyc_cnt <= '0;
    else if (state == CALC && cyc_cnt != '1)  cyc_cnt <= cyc_cnt + 1'b1;
  end
  assign cyc_word = cyc_cnt;
`else
  assign cyc_word = '0;
`endif

  // read data mux for the request being accepted
  always_comb begin
    rd_data = '0;
    case (req.addr)
      XR_GO:   rd_data = res_words[0];
      XR_RES:  rd_data = res_words[ptr];
      XR_CYC:  rd_data = cyc_word;
      default: rd_data = '0;
    endcase
  end

  // single response register, echoes type and opaque
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_val <= 1'b0;
      resp_msg <= '0;
    end else if (req_fire) begin
      resp_val          <= 1'b1;
      resp_msg.msg_type <= req.msg_type;
      resp_msg.data     <= (req.msg_type == MSG_WRITE) ? 32'd0 : rd_data;
      resp_msg.opaque   <= req.opaque;
    end else if (xcel.xcel_respstream_rdy) begin
      resp_val <= 1'b0;
    end
  end

  // operand registers load word-serially from host writes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base <= '0;
      exp  <= '0;
      mod  <= '0;
      r2   <= '0;
    end else if (req_fire && req.msg_type == MSG_WRITE) begin
      case (req.addr)
        XR_BASE: base <= shift_in(base, req.data);
        XR_EXP:  exp  <= shift_in(exp,  req.data);
        XR_MOD:  mod  <= shift_in(mod,  req.data);
        XR_R2:   r2   <= shift_in(r2,   req.data);
        default: ;
      endcase
    end
  end

  // choose the next Montgomery product; operands forward the previous result
  always_comb begin
    mm_start   = 1'b0;
    mm_a       = mm_result;
    mm_b       = mm_result;
    phase_next = phase;
    idx_next   = bit_idx;
    finish     = 1'b0;
    if (state == IDLE) begin
      if (go_fire && mod[0]) begin
        mm_start   = 1'b1;
        mm_a       = base;
        mm_b       = r2;
        phase_next = PRE_B;
      end
    end else if (mm_done) begin
      case (phase)
        PRE_B: begin
          mm_start   = 1'b1;
          mm_a       = ONE;
          mm_b       = r2;
          phase_next = PRE_ACC;
        end
        PRE_ACC: begin
          mm_start   = 1'b1;
          phase_next = SQR;
          idx_next   = IW'(NBITS - 1);
        end
        SQR: begin
          mm_start = 1'b1;
          if (exp[bit_idx]) begin
            mm_b       = bm;
            phase_next = MUL;
          end else if (bit_idx == '0) begin
            mm_b       = ONE;
            phase_next = POST;
          end else begin
            idx_next = bit_idx - 1'b1;
          end
        end
        MUL: begin
          mm_start = 1'b1;
          if (bit_idx == '0) begin
            mm_b       = ONE;
            phase_next = POST;
          end else begin
            idx_next   = bit_idx - 1'b1;
            phase_next = SQR;
          end
        end
        default: finish = 1'b1;
      endcase
    end
  end

  // control state, saved base product, result latch and read pointer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      phase   <= PRE_B;
      bit_idx <= '0;
      bm      <= '0;
      res     <= '0;
      ptr     <= PTR_RST;
    end else begin
      phase   <= phase_next;
      bit_idx <= idx_next;
      if (state == IDLE) begin
        if (go_fire) begin
          if (mod[0]) begin
            state <= CALC;
          end else begin
            res <= '0;
            ptr <= PTR_RST;
          end
        end else if (req_fire && req.msg_type == MSG_READ && req.addr == XR_RES) begin
          ptr <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
        end
      end else begin
        if (mm_done && phase == PRE_B) bm <= mm_result;
        if (finish) begin
          state <= IDLE;
          res   <= mm_result;
          ptr   <= PTR_RST;
        end
      end
    end
  end

  rsa_xcel_mont_MontMulSerial #(.NBITS(NBITS)) u_mm (
    .clk    (clk),
    .reset  (reset),
    .start  (mm_start),
    .a      (mm_a),
    .b      (mm_b),
    .n      (mod),
    .done   (mm_done),
    .result (mm_result)
  );
endmodule

// File: tb/tb_rsa_xcel_mont_param_xcel.sv
// Directed bench for rsa_xcel_mont_param_xcel at NBITS=32 and NBITS=64.
module tb_rsa_xcel_mont_param_xcel;
  import rsa_xcel_mont_param_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  rsa_xcel_mont_param_xcel_if if32 ();
  rsa_xcel_mont_param_xcel_if if64 ();

  rsa_xcel_mont_param_xcel #(.NBITS(32)) dut32 (.clk(clk), .reset(rst), .xcel(if32));
  rsa_xcel_mont_param_xcel #(.NBITS(64)) dut64 (.clk(clk), .reset(rst), .xcel(if64));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  function automatic logic req_rdy(input int d);
    return (d == 0) ? if32.xcel_reqstream_rdy : if64.xcel_reqstream_rdy;
  endfunction

  function automatic logic resp_val(input int d);
    return (d == 0) ? if32.xcel_respstream_val : if64.xcel_respstream_val;
  endfunction

  function automatic xcel_resp_t resp_msg(input int d);
    return (d == 0) ? if32.xcel_respstream_msg : if64.xcel_respstream_msg;
  endfunction

  task automatic drive(input int d, input logic v, input xcel_req_t m);
    if (d == 0) begin
      if32.xcel_reqstream_val = v;
      if32.xcel_reqstream_msg = m;
    end else begin
      if64.xcel_reqstream_val = v;
      if64.xcel_reqstream_msg = m;
    end
  endtask

  // one request/response pair with resp rdy high; prints one line
  task automatic xact(input int d, input logic wr, input logic [4:0] ad,
                      input logic [31:0] wdata, input logic [7:0] opq,
                      output logic [31:0] rdata);
    xcel_req_t  m;
    xcel_resp_t r;
    int n;
    m.msg_type = wr;
    m.addr     = ad;
    m.data     = wdata;
    m.opaque   = opq;
    @(negedge clk);
    drive(d, 1'b1, m);
    n = 0;
    while (!req_rdy(d) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("req_rdy_wait", req_rdy(d), 1'b1);
    @(posedge clk);
    #1;
    drive(d, 1'b0, '0);
    r = resp_msg(d);
    check("resp_val", resp_val(d), 1'b1);
    check("resp_opaque", r.opaque, opq);
    check("resp_type", r.msg_type, wr);
    rdata = r.data;
    $display("xact dut%0d wr=%0d addr=%0d wdata=0x%08h opq=0x%02h -> rdata=0x%08h",
             (d == 0) ? 32 : 64, wr, ad, wdata, opq, rdata);
  endtask

  task automatic wr_reg(input int d, input logic [4:0] ad, input logic [31:0] wdata);
    logic [31:0] rd;
    xact(d, MSG_WRITE, ad, wdata, 8'h5A, rd);
    check("wr_resp_data", rd, 32'd0);
  endtask

  task automatic load32(input logic [31:0] b, input logic [31:0] e,
                        input logic [31:0] n, input logic [31:0] r);
    wr_reg(0, XR_BASE, b);
    wr_reg(0, XR_EXP, e);
    wr_reg(0, XR_MOD, n);
    wr_reg(0, XR_R2, r);
  endtask

  initial begin
    logic [31:0] rd;
    int cyc;
    xcel_req_t  m;
    xcel_resp_t held;
    int exp_cyc;

`ifdef RSA_XCEL_MONT_CYCLE_COUNT_EN
    exp_cyc = 1254;
`else
    exp_cyc = 0;
`endif

    if32.xcel_reqstream_val = 1'b0;  if32.xcel_reqstream_msg = '0;  if32.xcel_respstream_rdy = 1'b1;
    if64.xcel_reqstream_val = 1'b0;  if64.xcel_reqstream_msg = '0;  if64.xcel_respstream_rdy = 1'b1;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_rdy32", req_rdy(0), 1'b1);
    check("rst_val32", resp_val(0), 1'b0);
    check("rst_msg32", resp_msg(0), '0);
    check("rst_rdy64", req_rdy(1), 1'b1);
    check("rst_val64", resp_val(1), 1'b0);

    // reads before any go, plus an unmapped address
    xact(0, MSG_READ, XR_GO, 0, 8'h01, rd);  check("pre_xr0_32", rd, 0);
    xact(0, MSG_READ, XR_RES, 0, 8'h02, rd); check("pre_xr5_32", rd, 0);
    xact(1, MSG_READ, XR_GO, 0, 8'h03, rd);  check("pre_xr0_64", rd, 0);
    xact(0, MSG_READ, 5'd9, 0, 8'h04, rd);   check("unmapped_rd", rd, 0);

    // 4^13 mod 497 = 445, latency (3+32+3)*33
    load32(32'd4, 32'd13, 32'd497, 32'd436);
    xact(0, MSG_WRITE, XR_GO, 0, 8'h10, rd);
    check("go_resp_data", rd, 0);
    check("calc_rdy_low", req_rdy(0), 1'b0);
    cyc = 0;
    while (!req_rdy(0) && cyc < 5000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("latency", cyc, 1254);
    xact(0, MSG_READ, XR_GO, 0, 8'h12, rd);  check("modexp_445", rd, 445);
    xact(0, MSG_READ, XR_RES, 0, 8'h13, rd); check("xr5_nw1", rd, 445);
    xact(0, MSG_READ, XR_CYC, 0, 8'h14, rd); check("xr6", rd, exp_cyc);

    // even modulus: no CALC, result 0
    wr_reg(0, XR_MOD, 32'd100);
    xact(0, MSG_WRITE, XR_GO, 0, 8'h20, rd);
    check("even_rdy", req_rdy(0), 1'b1);
    xact(0, MSG_READ, XR_GO, 0, 8'h21, rd);  check("even_res", rd, 0);

    // exp 0 gives 1, twice without reload
    load32(32'd123, 32'd0, 32'd497, 32'd436);
    xact(0, MSG_WRITE, XR_GO, 0, 8'h30, rd);
    xact(0, MSG_READ, XR_GO, 0, 8'h31, rd);  check("exp0_a", rd, 1);
    xact(0, MSG_WRITE, XR_GO, 0, 8'h32, rd);
    xact(0, MSG_READ, XR_GO, 0, 8'h33, rd);  check("exp0_b", rd, 1);

    // response backpressure: even-mod go (0x11) then read (0x22)
    wr_reg(0, XR_MOD, 32'd100);
    @(posedge clk);
    @(negedge clk);
    if32.xcel_respstream_rdy = 1'b0;
    m.msg_type = MSG_WRITE; m.addr = XR_GO; m.data = 0; m.opaque = 8'h11;
    drive(0, 1'b1, m);
    @(posedge clk);
    #1;
    m.msg_type = MSG_READ; m.addr = XR_GO; m.data = 0; m.opaque = 8'h22;
    drive(0, 1'b1, m);
    held = resp_msg(0);
    check("bp_first_opq", held.opaque, 8'h11);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_rdy_low", req_rdy(0), 1'b0);
      check("bp_val_held", resp_val(0), 1'b1);
      check("bp_msg_held", resp_msg(0), held);
      $display("backpressure cycle %0d opq=0x%02h", i, resp_msg(0).opaque);
    end
    @(negedge clk);
    if32.xcel_respstream_rdy = 1'b1;
    #1;
    check("bp_rdy_back", req_rdy(0), 1'b1);
    @(posedge clk);
    #1;
    drive(0, 1'b0, '0);
    check("bp_second_val", resp_val(0), 1'b1);
    check("bp_second_opq", resp_msg(0).opaque, 8'h22);
    check("bp_second_type", resp_msg(0).msg_type, MSG_READ);
    $display("backpressure released opq=0x%02h", resp_msg(0).opaque);

    // NBITS=64: 2^10 mod (2^64-59) = 1024
    wr_reg(1, XR_BASE, 32'd2);          wr_reg(1, XR_BASE, 32'd0);
    wr_reg(1, XR_EXP, 32'd10);          wr_reg(1, XR_EXP, 32'd0);
    wr_reg(1, XR_MOD, 32'hFFFF_FFC5);   wr_reg(1, XR_MOD, 32'hFFFF_FFFF);
    wr_reg(1, XR_R2, 32'h0000_0D99);    wr_reg(1, XR_R2, 32'd0);
    xact(1, MSG_WRITE, XR_GO, 0, 8'h40, rd);
    check("calc_rdy_low64", req_rdy(1), 1'b0);
    xact(1, MSG_READ, XR_GO, 0, 8'h41, rd);  check("w0_64", rd, 1024);
    xact(1, MSG_READ, XR_RES, 0, 8'h42, rd); check("w1_64", rd, 0);
    xact(1, MSG_READ, XR_RES, 0, 8'h43, rd); check("wrap_64", rd, 1024);

    // reset in the middle of CALC, then a full transaction
    load32(32'd4, 32'd13, 32'd497, 32'd436);
    xact(0, MSG_WRITE, XR_GO, 0, 8'h50, rd);
    repeat (100) @(posedge clk);
    @(negedge clk);
    check("mid_calc_rdy", req_rdy(0), 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("async_rdy", req_rdy(0), 1'b1);
    check("async_val", resp_val(0), 1'b0);
    check("async_msg", resp_msg(0), '0);
    @(negedge clk);
    rst = 1'b0;
    xact(0, MSG_READ, XR_GO, 0, 8'h51, rd);  check("post_rst_res", rd, 0);
    load32(32'd4, 32'd13, 32'd497, 32'd436);
    xact(0, MSG_WRITE, XR_GO, 0, 8'h52, rd);
    xact(0, MSG_READ, XR_GO, 0, 8'h53, rd);  check("post_rst_445", rd, 445);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end
endmodule
